spmv_mem_arbiter: RTL
=====================

# spmv_mem_arbiter

Shares the single tile-accelerator memory request port (to L2 over the NoC) between the SpMV requesters: vector prefetch, value/column-index stream, and row-length stream. Each accepted request is assigned a free 6-bit transaction ID; responses are routed back to the requester that owns that ID. The block sits between the SpMV control FSM/channel units and the `mem_req_*`/`mem_resp_*` ports of `tight_acc_iface`.

## Interface
- `NUM_REQ`, default 4, number of requesters (2..8).
- `MAX_OUTSTANDING`, default 64, in-flight cap (1..64).
- `clk` in 1: single clock.
- `rst` in 1: synchronous reset, active-high.
- `req_val` in `NUM_REQ`: request valid per requester.
- `req_rdy` out `NUM_REQ`: request accepted this cycle.
- `req_addr` in `NUM_REQ*40`: physical address per requester (`DCP_PADDR` width); requester i occupies bits `[40i+39:40i]`.
- `mem_req_val` out 1: request to memory.
- `mem_req_rdy` in 1: network accepts the request.
- `mem_req_transid` out 6: allocated ID.
- `mem_req_addr` out 40: granted address.
- `mem_resp_val` in 1: memory response.
- `mem_resp_transid` in 6: response ID.
- `mem_resp_data` in `DCP_NOC_RES_DATA_SIZE`: response line.
- `resp_val` out `NUM_REQ`: one-hot response strobe.
- `resp_data` out `DCP_NOC_RES_DATA_SIZE`: registered response data, shared by all requesters.
- `outstanding` out 7: current in-flight count.
- `idle` out 1: `outstanding==0`.
- `err_spurious` out 1: sticky error flag (see Configuration).

## Operation
- State: `free_map[63:0]` bitmap (1 = free; bits at or above `MAX_OUTSTANDING` are never free), `owner[64]` table of `$clog2(NUM_REQ)` bits each, round-robin pointer `rr_ptr`, and the `outstanding` counter.
- Grant: round-robin over `req_val`. Search starts at `rr_ptr`. After a handshake, `rr_ptr` moves to the granted index + 1, modulo `NUM_REQ`. Without a handshake, `rr_ptr` holds.
- `mem_req_val = |req_val && |free_map`. Address is that of the granted requester. `mem_req_transid` is the lowest-index free bit of the registered `free_map`.
- Handshake: `mem_req_val && mem_req_rdy` asserts `req_rdy[grant]` in the same cycle, clears the free bit, writes `owner[tid] = grant`, and increments `outstanding`.
- Response: on `mem_resp_val`, `resp_val[owner[tid]]` and `resp_data` are registered and appear the next cycle. The free bit is set and `outstanding` decrements.
- Simultaneous allocate and free in one cycle: `outstanding` is unchanged. The ID freed this cycle is not allocatable until the next cycle.
- Full (`outstanding==MAX_OUTSTANDING`): `mem_req_val=0` and all `req_rdy=0`. Requesters keep `req_val` and `req_addr` stable until accepted.
- Responses are always accepted. The block applies no backpressure on `mem_resp`, and requesters must consume `resp_val` in the cycle it is asserted.

## Timing
- Request path is combinational: `req_val`/`mem_req_rdy` to `mem_req_val`/`req_rdy` in the same cycle.
- Response latency is exactly 1 cycle, from `mem_resp_val` to `resp_val`.
- Values while `rst` is high and in the first cycle after reset:
  - `free_map` = low `MAX_OUTSTANDING` bits set.
  - `owner` = 0 and `rr_ptr` = 0.
  - `outstanding` = 0 and `idle` = 1.
  - `resp_val` = 0, `resp_data` = 0, `err_spurious` = 0.
  - `mem_req_val` = 0 while `rst` is high.
- Reset during operation discards all in-flight IDs. Responses arriving after reset for pre-reset IDs are spurious.

## Configuration
- `SPMV_MEM_ARB_ERR_EN` defined:
  - A response whose ID is currently free, or at or above `MAX_OUTSTANDING`, is dropped: no `resp_val`, no counter change.
  - `err_spurious` is set and stays set until `rst`.
- `SPMV_MEM_ARB_ERR_EN` undefined:
  - No check is made. The response is routed to `owner[tid]` and the bit is set free.
  - `outstanding` saturates at 0 and never wraps.
  - `err_spurious` is tied to 0.

## Structure
- Package `spmv_pkg` holds: `SPMV_TID_W=6`, `SPMV_PADDR_W=40`, requester index enum (`REQ_VEC_PF=0`, `REQ_VAL_COL=1`, `REQ_ROW_LEN=2`, `REQ_SPARE=3`).
- Sub-module `spmv_rr_arbiter`: parameterised N-way round-robin. Inputs: `req`, `advance`. Outputs: one-hot `grant`, `grant_idx`. Pointer is held internally.
- Lowest-free-ID selection is a priority encoder inside the top module.

## Test plan
- Single requester 0, addr `0x10_0000_0040`, `mem_req_rdy=1` → transid 0 issued with `req_rdy[0]` in the same cycle. Response tid 0 → `resp_val=4'b0001` one cycle later, with data matching.
- All four requesters valid continuously, `mem_req_rdy=1` → grant order 0,1,2,3,0; transids 0,1,2,3,4.
- `MAX_OUTSTANDING=4`, issue 4 with no responses → `mem_req_val=0` and `outstanding=4`. A response for tid 2 plus a pending request in the same cycle → no allocation that cycle; the next cycle issues tid 2.
- Out-of-order responses for tids 3,0,1 → `resp_val` goes to each owner, `outstanding` decrements to 1, `idle` stays 0.
- `mem_req_rdy=0` for 5 cycles with req 1 valid → `req_rdy=0`, address stable, `rr_ptr` unchanged. Then rdy=1 → req 1 is granted.
- With `SPMV_MEM_ARB_ERR_EN`, response tid 9 never issued → no `resp_val`, `err_spurious=1` held. Assert `rst` → all state at reset values.

Source files
------------

// File: rtl/spmv_pkg.sv
// -----------------------------------------------------------------------------
// spmv_pkg
// Shared constants and types for the SpMV memory-request arbiter.
//   SPMV_TID_W        : transaction-ID width towards the NoC
//   SPMV_PADDR_W      : physical address width
//   SPMV_RESP_DATA_W  : default response line width
//   spmv_req_e        : fixed requester slot assignment
//   spmv_tid_mask()   : bitmap of IDs that may ever be allocated
// -----------------------------------------------------------------------------
package spmv_pkg;

   localparam int SPMV_TID_W       = 6;
   localparam int SPMV_PADDR_W     = 40;
   localparam int SPMV_RESP_DATA_W = 64;
   localparam int SPMV_NUM_TID     = 64;

   typedef enum logic [1:0] {
      REQ_VEC_PF  = 2'd0,
      REQ_VAL_COL = 2'd1,
      REQ_ROW_LEN = 2'd2,
      REQ_SPARE   = 2'd3
   } spmv_req_e;

   // IDs below max_out are usable; everything above stays permanently busy.
   function automatic logic [63:0] spmv_tid_mask(input int max_out);
      logic [63:0] m;
      m = (max_out >= 64) ? {64{1'b1}} : ((64'd1 << max_out) - 64'd1);
      return m;
   endfunction

endpackage

// File: rtl/spmv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spmv_rr_arbiter
// N-way round-robin arbiter. The search starts at the internal pointer; the
// pointer moves past the winner only when the grant is consumed (advance).
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   req        : request vector
//   advance    : grant was accepted this cycle
//   grant      : one-hot grant (combinational)
//   grant_idx  : binary index of grant (combinational)
// -----------------------------------------------------------------------------
module spmv_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] r_ptr;
   logic [N-1:0]     w_grant;
   logic [IDX_W-1:0] w_idx;
   logic             w_found;
   int               w_pos;

   // Rotating priority search beginning at r_ptr.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int k = 0; k < N; k++) begin
         w_pos = int'(r_ptr) + k;
         w_pos = (w_pos >= N) ? (w_pos - N) : w_pos;
         if (!w_found && req[IDX_W'(w_pos)]) begin
            w_found                 = 1'b1;
            w_grant[IDX_W'(w_pos)]  = 1'b1;
            w_idx                   = IDX_W'(w_pos);
         end else begin
            w_found = w_found;
         end
      end
   end

   // Pointer moves to winner+1 (mod N) only on an accepted grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (advance) begin
         r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : (w_idx + IDX_W'(1));
      end
   end

   assign grant     = w_grant;
   assign grant_idx = w_idx;

endmodule

// File: rtl/spmv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// spmv_mem_arbiter
// Shares the accelerator memory request port between SpMV requesters, hands
// out the lowest free 6-bit transaction ID per accepted request and routes
// each response back to the requester owning that ID.
// Configuration macro: SPMV_MEM_ARB_ERR_EN
//   defined   : responses for free / out-of-range IDs are dropped and set the
//               sticky err_spurious flag
//   undefined : no check; the in-flight counter saturates at zero
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_val/req_rdy/req_addr  : per-requester request handshake + address
//   mem_req_*                 : request towards the NoC (combinational)
//   mem_resp_*                : response from the NoC (never backpressured)
//   resp_val/resp_data        : registered one-hot response strobe + line
//   outstanding/idle          : in-flight count and its zero flag
//   err_spurious              : sticky spurious-response flag
// -----------------------------------------------------------------------------
module spmv_mem_arbiter
   import spmv_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 64,
   parameter int DATA_W          = SPMV_RESP_DATA_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_val,
   output logic [NUM_REQ-1:0]             req_rdy,
   input  logic [NUM_REQ*SPMV_PADDR_W-1:0] req_addr,
   output logic                           mem_req_val,
   input  logic                           mem_req_rdy,
   output logic [SPMV_TID_W-1:0]          mem_req_transid,
   output logic [SPMV_PADDR_W-1:0]        mem_req_addr,
   input  logic                           mem_resp_val,
   input  logic [SPMV_TID_W-1:0]          mem_resp_transid,
   input  logic [DATA_W-1:0]              mem_resp_data,
   output logic [NUM_REQ-1:0]             resp_val,
   output logic [DATA_W-1:0]              resp_data,
   output logic [6:0]                     outstanding,
   output logic                           idle,
   output logic                           err_spurious
);

   localparam int          OWN_W    = $clog2(NUM_REQ);
   localparam logic [63:0] TID_MASK = spmv_tid_mask(MAX_OUTSTANDING);

   logic [63:0]              r_free_map;
   logic [OWN_W-1:0]         r_owner [SPMV_NUM_TID];
   logic [6:0]               r_outstanding;
   logic                     r_idle;
   logic [NUM_REQ-1:0]       r_resp_val;
   logic [DATA_W-1:0]        r_resp_data;

   logic [NUM_REQ-1:0]       w_grant;
   logic [OWN_W-1:0]         w_grant_idx;
   logic [SPMV_TID_W-1:0]    w_free_tid;
   logic [SPMV_PADDR_W-1:0]  w_addr;
   logic                     w_mem_req_val;
   logic                     w_hs;
   logic                     w_resp_ok;
   logic [OWN_W-1:0]         w_resp_owner;
   logic [NUM_REQ-1:0]       w_resp_onehot;
   logic [63:0]              w_free_nxt;
   logic [6:0]               w_out_nxt;

   spmv_rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (OWN_W)
   ) u_rr (
      .clk       (clk),
      .rst       (rst),
      .req       (req_val),
      .advance   (w_hs),
      .grant     (w_grant),
      .grant_idx (w_grant_idx)
   );

   // Lowest-index free ID: scan downwards so the last hit is the lowest bit.
   always_comb begin
      w_free_tid = '0;
      for (int t = SPMV_NUM_TID - 1; t >= 0; t--) begin
         w_free_tid = r_free_map[6'(t)] ? 6'(t) : w_free_tid;
      end
   end

   // Address mux for the granted requester.
   always_comb begin
      w_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_addr = (w_grant_idx == OWN_W'(i)) ? req_addr[i*SPMV_PADDR_W +: SPMV_PADDR_W] : w_addr;
      end
   end

   assign w_mem_req_val = !rst && (|req_val) && (|r_free_map);
   assign w_hs          = w_mem_req_val && mem_req_rdy;
   assign w_resp_owner  = r_owner[mem_resp_transid];
   assign w_resp_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_resp_owner;

`ifdef SPMV_MEM_ARB_ERR_EN
   logic w_spur;
   logic r_err;
   // A response is legitimate only if its ID is usable and currently in flight.
   assign w_resp_ok = mem_resp_val && TID_MASK[mem_resp_transid] && !r_free_map[mem_resp_transid];
   assign w_spur    = mem_resp_val && !w_resp_ok;

   // Sticky spurious-response flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= r_err | w_spur;
      end
   end
   assign err_spurious = r_err;
`else
   assign w_resp_ok    = mem_resp_val;
   assign err_spurious = 1'b0;
`endif

   // Next free map: allocation clears, response frees (masked so IDs beyond the
   // cap stay busy). Allocation reads the registered map, so an ID freed this
   // cycle is only allocatable next cycle.
   always_comb begin
      w_free_nxt = r_free_map;
      for (int t = 0; t < SPMV_NUM_TID; t++) begin
         w_free_nxt[6'(t)] = (w_hs && (w_free_tid == 6'(t))) ? 1'b0 :
                             ((w_resp_ok && (mem_resp_transid == 6'(t))) ? TID_MASK[6'(t)] : r_free_map[6'(t)]);
      end
   end

   // In-flight counter; a decrement at zero (spurious, unchecked build) holds.
   always_comb begin
      case ({w_hs, w_resp_ok})
         2'b10:   w_out_nxt = r_outstanding + 7'd1;
         2'b01:   w_out_nxt = (r_outstanding == 7'd0) ? 7'd0 : (r_outstanding - 7'd1);
         default: w_out_nxt = r_outstanding;
      endcase
   end

   // ID bookkeeping state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_free_map    <= TID_MASK;
         r_outstanding <= 7'd0;
         r_idle        <= 1'b1;
         for (int t = 0; t < SPMV_NUM_TID; t++) begin
            r_owner[t] <= '0;
         end
      end else begin
         r_free_map    <= w_free_nxt;
         r_outstanding <= w_out_nxt;
         r_idle        <= (w_out_nxt == 7'd0);
         if (w_hs) begin
            r_owner[w_free_tid] <= w_grant_idx;
         end
      end
   end

   // Registered response strobe and shared data line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_val  <= '0;
         r_resp_data <= '0;
      end else begin
         r_resp_val <= w_resp_ok ? w_resp_onehot : '0;
         if (w_resp_ok) begin
            r_resp_data <= mem_resp_data;
         end
      end
   end

   assign mem_req_val     = w_mem_req_val;
   assign mem_req_transid = w_free_tid;
   assign mem_req_addr    = w_addr;
   assign req_rdy         = w_grant & {NUM_REQ{w_hs}};
   assign resp_val        = r_resp_val;
   assign resp_data       = r_resp_data;
   assign outstanding     = r_outstanding;
   assign idle            = r_idle;

endmodule
